cla_seq32: RTL
==============

CLA_SEQ32 -- requirements
Module: cla_seq32

Interface
REQ-001 Parameter SHALL be: NBYTES, default 4, operand width in bytes (legal 1..8); W = 8*NBYTES.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse; operands are sampled when the request is accepted.
REQ-005 a  input  W  operand A.
REQ-006 b  input  W  operand B.
REQ-007 cin  input  1  carry-in to byte 0.
REQ-008 sub  input  1  subtract select; this port SHALL exist only when CLA_SEQ_SUB_EN is defined.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 sum  output  W  registered result.
REQ-012 cout  output  1  final carry out of byte NBYTES-1.
REQ-013 ovf  output  1  two's-complement overflow of the W-bit result.

Function
REQ-014 The block SHALL instantiate exactly one 8-bit carry-lookahead adder (CLA8) and time-share it, adding one byte per cycle from LSB to MSB.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 A request SHALL be accepted on an edge where start=1 in IDLE or DONE; on acceptance a, b and cin (and sub) SHALL be latched, the byte index SHALL be set to 0, and the state SHALL go to RUN.
REQ-017 start SHALL be ignored in RUN, and the latched operands SHALL NOT change.
REQ-018 In RUN, byte k SHALL feed a_r[8k+7:8k], b_r[8k+7:8k] and the carry register into the adder; SUM[7:0] SHALL be stored in accumulator byte k and SUM[8] in the carry register.
REQ-019 The carry register SHALL be loaded with the latched cin on acceptance.
REQ-020 After byte NBYTES-1 is processed, the state SHALL go to DONE; done=1 for exactly that one cycle, then the state SHALL go to IDLE unless start=1.
REQ-021 Latency SHALL be as follows: with start accepted at edge t, done is high in the cycle after edge t+NBYTES, and the next acceptance is possible at edge t+NBYTES+1 (back-to-back).
REQ-022 busy SHALL be 1 exactly in RUN.
REQ-023 sum, cout and ovf SHALL update only at the edge that enters DONE, and SHALL hold until the next completion or reset.
REQ-024 ovf SHALL equal (carry into bit W-1) XOR cout.
REQ-025 Results SHALL wrap modulo 2^W; the carry beyond cout SHALL be discarded.
REQ-026 With NBYTES=1, RUN SHALL last one cycle.

Reset
REQ-027 rst=1 at any edge SHALL force IDLE and clear busy, done, sum, cout, ovf, the accumulator, the carry register and the byte index to 0.
REQ-028 rst SHALL take priority over start.
REQ-029 A reset during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-030 When CLA_SEQ_SUB_EN is defined and sub=1 at acceptance, the block SHALL latch ~b and force the carry register to 1 (cin ignored), computing a-b; cout=1 SHALL mean no borrow, and ovf SHALL be signed subtraction overflow.
REQ-031 When CLA_SEQ_SUB_EN is undefined, the sub port and its logic SHALL be absent and only a+b+cin SHALL be computed.

Verification (NBYTES=4)
REQ-032 a=0xFFFFFFFF, b=1, cin=0 -> sum=0x00000000, cout=1, ovf=0, done exactly 4 cycles after the start edge, busy high for 4 cycles.
REQ-033 a=0x7FFFFFFF, b=1, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-034 a=0, b=0, cin=1 -> sum=0x00000001; then a=0xFFFFFFFF, b=0xFFFFFFFF with start held through done -> second result 0xFFFFFFFE, cout=1, accepted back-to-back with no IDLE cycle.
REQ-035 start with a=5, b=3, then start re-pulsed with a=0xFF during RUN -> second start ignored, sum=0x00000008, a single done pulse.
REQ-036 rst asserted at the 2nd RUN cycle -> no done pulse, all outputs 0 on the next cycle; the next start with a=10, b=5 -> sum=15.
REQ-037 With CLA_SEQ_SUB_EN defined: sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0; and a=0x80000000, b=1 -> sum=0x7FFFFFFF, ovf=1.

Source files
------------

// File: rtl/cla_seq32.sv
// Byte-serial adder built around a single 8-bit carry-lookahead adder (cla8).
// One operand byte is added per cycle, LSB first; the carry is kept in a
// register between bytes. Optional feature macro: CLA_SEQ_SUB_EN adds a
// 'sub' port that turns the operation into a - b.

module cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [8:0] s,
  output logic       c7
);

  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;
  logic       gg;
  logic       pp;

  // Each carry is a flattened group generate/propagate over bits [i:0], not a ripple chain.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    gg   = 1'b0;
    pp   = 1'b0;
    c[0] = ci;
    for (int i = 0; i < 8; i++) begin
      gg = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        gg = gg | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = gg | (pp & ci);
    end
    s  = {c[8], p ^ c[7:0]};
    c7 = c[7];
  end

endmodule

module cla_seq32 #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                  sub,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_r, b_r;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    sum_q;
  logic            carry_q;
  logic            cout_q, ovf_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    b_in;
  logic            c_in;
  logic            accept;
  logic            last;
  logic [7:0]      op_a, op_b;
  logic [8:0]      add_s;
  logic            add_c7;

  cla8 u_cla8 (
    .a  (op_a),
    .b  (op_b),
    .ci (carry_q),
    .s  (add_s),
    .c7 (add_c7)
  );

  // Acceptance, operand conditioning and byte selection for the shared adder.
  always_comb begin
    accept = start && (state_q != StRun);
    last   = (idx_q == IW'(NBYTES - 1));
    b_in   = b;
    c_in   = cin;
`ifdef CLA_SEQ_SUB_EN
    // a - b == a + ~b + 1
    if (sub) begin
      b_in = ~b;
      c_in = 1'b1;
    end
`endif
    op_a  = a_r[8*idx_q +: 8];
    op_b  = b_r[8*idx_q +: 8];
    acc_d = acc_q;
    acc_d[8*idx_q +: 8] = add_s[7:0];
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Operand latch, per-byte accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_r     <= a;
      b_r     <= b_in;
      carry_q <= c_in;
      idx_q   <= '0;
    end else if (state_q == StRun) begin
      acc_q   <= acc_d;
      carry_q <= add_s[8];
      if (last) begin
        idx_q  <= '0;
        sum_q  <= acc_d;
        cout_q <= add_s[8];
        ovf_q  <= add_c7 ^ add_s[8];
      end else begin
        idx_q  <= idx_q + IW'(1);
      end
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
